// File: rtl/mouse_pkg.sv
// ---------------------------------------------------------------------------
// mouse_pkg : PS/2 mouse packet decoder states and status-byte bit positions.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mouse_pkg;
  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, UPDATE} mouse_state_t;

  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;
endpackage

`default_nettype wire

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg : visible-area resolution shared by the 800x600 timing chain.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

`default_nettype wire

// File: rtl/mouse_axis_accum.sv
// ---------------------------------------------------------------------------
// mouse_axis_accum : adds a signed 9-bit movement to one axis, clamps to 0..LIMIT-1.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mouse_axis_accum #(
  parameter int LIMIT = 800,
  parameter bit SUB   = 1'b0
) (
  input  logic [11:0] cur,
  input  logic [8:0]  delta9,
  input  logic        ovf,
  output logic [11:0] next
);
  localparam logic signed [12:0] LIM = 13'(LIMIT);
  localparam logic [11:0]        MAX = 12'(LIMIT - 1);

  logic signed [12:0] delta13;
  logic signed [12:0] sum;

  // Subtracting here rather than negating upstream keeps delta=-256 exact.
  always_comb begin
    delta13 = {{4{delta9[8]}}, delta9};
    if (SUB) sum = $signed({1'b0, cur}) - delta13;
    else     sum = $signed({1'b0, cur}) + delta13;

    if (ovf)                 next = cur;
    else if (sum < 13'sd0)   next = 12'd0;
    else if (sum >= LIM)     next = MAX;
    else                     next = sum[11:0];
  end
endmodule

`default_nettype wire

// File: rtl/mouse_pos_tracker.sv
// ---------------------------------------------------------------------------
// mouse_pos_tracker : assembles PS/2 mouse packets into a clamped cursor position,
// published to the overlay once per frame at vblank start.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mouse_pos_tracker
  import vga_pkg::*;
  import mouse_pkg::*;
#(
  parameter int H_RES        = HOR_PIXELS,
  parameter int V_RES        = VER_PIXELS,
  parameter int X_INIT       = 400,
  parameter int Y_INIT       = 300,
  parameter int BYTE_TIMEOUT = 40000
) (
  input  logic        clk40MHz,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        left,
  output logic        right,
  output logic        pkt_err
);
  localparam int             TW       = $clog2(BYTE_TIMEOUT);
  localparam logic [TW-1:0]  TMO_LAST = TW'(BYTE_TIMEOUT - 1);

  mouse_state_t   state_q, state_d;
  logic [7:0]     status_q, status_d;
  logic [7:0]     dx_lo_q, dx_lo_d;
  logic [7:0]     dy_lo_q, dy_lo_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [11:0]    x_q, x_d, y_q, y_d;
  logic [11:0]    xpos_q, xpos_d, ypos_q, ypos_d;
  logic           left_q, left_d, right_q, right_d;
  logic           pkt_err_q, pkt_err_d;
  logic           vblnk_dly_q, vblnk_dly_d;
  logic [11:0]    nx, ny;

  mouse_axis_accum #(.LIMIT(H_RES), .SUB(1'b0)) u_x_accum (
    .cur    (x_q),
    .delta9 ({status_q[XSIGN], dx_lo_q}),
    .ovf    (status_q[XOVF]),
    .next   (nx)
  );

  // PS/2 reports up as positive while screen y grows downward.
  mouse_axis_accum #(.LIMIT(V_RES), .SUB(1'b1)) u_y_accum (
    .cur    (y_q),
    .delta9 ({status_q[YSIGN], dy_lo_q}),
    .ovf    (status_q[YOVF]),
    .next   (ny)
  );

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    dx_lo_d     = dx_lo_q;
    dy_lo_d     = dy_lo_q;
    tmo_d       = '0;
    x_d         = x_q;
    y_d         = y_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    left_d      = left_q;
    right_d     = right_q;
    pkt_err_d   = 1'b0;
    vblnk_dly_d = vblnk;

    // Publishes x_q/y_q as they stand, so an UPDATE in this cycle lands next frame.
    if (vblnk && !vblnk_dly_q) begin
      xpos_d = x_q;
      ypos_d = y_q;
    end

    case (state_q)
      BYTE0, UPDATE: begin
        if (state_q == UPDATE) begin
          x_d     = nx;
          y_d     = ny;
          left_d  = status_q[0];
          right_d = status_q[1];
          state_d = BYTE0;
        end
        if (rx_valid) begin
          if (rx_data[SYNC]) begin
            status_d = rx_data;
            state_d  = BYTE1;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
      end
      BYTE1: begin
        if (rx_valid) begin
          dx_lo_d = rx_data;
          state_d = BYTE2;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = BYTE0;
          pkt_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BYTE2: begin
        if (rx_valid) begin
          dy_lo_d = rx_data;
          state_d = UPDATE;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = BYTE0;
          pkt_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = BYTE0;
    endcase
  end

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state_q     <= BYTE0;
      status_q    <= 8'd0;
      dx_lo_q     <= 8'd0;
      dy_lo_q     <= 8'd0;
      tmo_q       <= '0;
      x_q         <= 12'(X_INIT);
      y_q         <= 12'(Y_INIT);
      xpos_q      <= 12'(X_INIT);
      ypos_q      <= 12'(Y_INIT);
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      pkt_err_q   <= 1'b0;
      vblnk_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      dx_lo_q     <= dx_lo_d;
      dy_lo_q     <= dy_lo_d;
      tmo_q       <= tmo_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      left_q      <= left_d;
      right_q     <= right_d;
      pkt_err_q   <= pkt_err_d;
      vblnk_dly_q <= vblnk_dly_d;
    end
  end

  assign xpos    = xpos_q;
  assign ypos    = ypos_q;
  assign left    = left_q;
  assign right   = right_q;
  assign pkt_err = pkt_err_q;
endmodule

`default_nettype wire

// File: tb/tb_mouse_pos_tracker.sv
// ---------------------------------------------------------------------------
// tb_mouse_pos_tracker : directed packet sequences with hand-computed positions.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mouse_pos_tracker;
  logic        clk40MHz = 1'b0;
  logic        rst      = 1'b1;
  logic [7:0]  rx_data  = 8'd0;
  logic        rx_valid = 1'b0;
  logic        vblnk    = 1'b0;
  logic [11:0] xpos, ypos;
  logic        left, right, pkt_err;

  int vectors    = 0;
  int miscompares = 0;

  mouse_pos_tracker dut (
    .clk40MHz (clk40MHz),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .vblnk    (vblnk),
    .xpos     (xpos),
    .ypos     (ypos),
    .left     (left),
    .right    (right),
    .pkt_err  (pkt_err)
  );

  always #12 clk40MHz = ~clk40MHz;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk40MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; vblnk = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Three back-to-back bytes, then the UPDATE cycle.
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0); send_byte(b1); send_byte(b2);
    tick();
  endtask

  task automatic vblank();
    vblnk = 1'b1; tick();
    vblnk = 1'b0; tick();
  endtask

  initial begin
    logic early;

    // Reset state and first publication
    do_reset();
    check("rst_xpos", xpos, 12'd400);
    check("rst_ypos", ypos, 12'd300);
    check("rst_left", {11'd0, left}, 12'd0);
    check("rst_right", {11'd0, right}, 12'd0);
    check("rst_pkt_err", {11'd0, pkt_err}, 12'd0);
    vblank();
    check("vb0_xpos", xpos, 12'd400);
    check("vb0_ypos", ypos, 12'd300);

    // dx=+10, dy=+5, left pressed
    send_pkt(8'h09, 8'h0A, 8'h05);
    vblank();
    check("p1_xpos", xpos, 12'd410);
    check("p1_ypos", ypos, 12'd295);
    check("p1_left", {11'd0, left}, 12'd1);
    check("p1_right", {11'd0, right}, 12'd0);

    // dx=-128 from x=400: 272, 144, 16, then clamp at 0
    do_reset();
    repeat (3) send_pkt(8'h18, 8'h80, 8'h00);
    vblank();
    check("neg3_xpos", xpos, 12'd16);
    check("neg3_left", {11'd0, left}, 12'd0);
    send_pkt(8'h18, 8'h80, 8'h00);
    vblank();
    check("neg4_xpos", xpos, 12'd0);
    check("neg4_ypos", ypos, 12'd300);

    // dy=-128 moves down: 428, 556, clamp at 599
    repeat (3) send_pkt(8'h28, 8'h00, 8'h80);
    vblank();
    check("ydn_ypos", ypos, 12'd599);
    check("ydn_xpos", xpos, 12'd0);

    // Framing error, then two packets with the second arriving in UPDATE
    send_byte(8'h00);
    check("sync_err_pulse", {11'd0, pkt_err}, 12'd1);
    tick();
    check("sync_err_clear", {11'd0, pkt_err}, 12'd0);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h00);
    tick();
    check("b2b_no_err", {11'd0, pkt_err}, 12'd0);
    vblank();
    check("b2b_xpos", xpos, 12'd2);
    check("b2b_ypos", ypos, 12'd599);

    // Timeout: pkt_err rises exactly BYTE_TIMEOUT cycles after the last byte
    send_byte(8'h08);
    send_byte(8'h05);
    early = 1'b0;
    for (int i = 0; i < 39999; i++) begin
      tick();
      if (pkt_err) early = 1'b1;
    end
    check("tmo_not_early", {11'd0, early}, 12'd0);
    tick();
    check("tmo_pulse", {11'd0, pkt_err}, 12'd1);
    tick();
    check("tmo_clear", {11'd0, pkt_err}, 12'd0);
    send_pkt(8'h08, 8'h02, 8'h00);
    vblank();
    check("tmo_xpos", xpos, 12'd4);
    check("tmo_ypos", ypos, 12'd599);

    // X overflow ignores dx; y still moves up by 3
    send_pkt(8'h48, 8'hFF, 8'h03);
    vblank();
    check("xovf_xpos", xpos, 12'd4);
    check("xovf_ypos", ypos, 12'd596);

    // UPDATE coincides with vblank start: old value published first
    send_byte(8'h0A); send_byte(8'h04); send_byte(8'h00);
    vblnk = 1'b1;
    tick();
    vblnk = 1'b0;
    check("coinc_old_xpos", xpos, 12'd4);
    check("coinc_right", {11'd0, right}, 12'd1);
    check("coinc_left", {11'd0, left}, 12'd0);
    tick();
    vblank();
    check("coinc_new_xpos", xpos, 12'd8);
    check("coinc_new_ypos", ypos, 12'd596);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
